gcd_arbiter: RTL and testbench
==============================

// Module: gcd_arbiter
// PURPOSE
//  Shares one gcd_top instance between NREQ independent clients. Each client
//  presents both operands in parallel on its own 4-phase req/ack channel. The
//  arbiter grants clients round-robin, sequences the two-operand serial
//  req/ack protocol of gcd_top (A first, then B) and returns the result.
//  Sits between client logic and gcd_top. The parent inverts reset for gcd_top.
// PARAMETERS
//  NREQ  4   number of clients, 2..8
//  W     16  operand/result width; must match gcd_top AB/C width
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-low reset
//  cli_req  in   NREQ    per-client request, 4-phase
//  cli_a    in   NREQ*W  client i operand A in bits [i*W +: W]
//  cli_b    in   NREQ*W  client i operand B in bits [i*W +: W]
//  cli_ack  out  NREQ    per-client acknowledge, one-hot or zero
//  cli_c    out  W       result; valid while any cli_ack bit is high
//  gcd_req  out  1       request to gcd_top
//  gcd_ab   out  W       operand to gcd_top
//  gcd_ack  in   1       acknowledge from gcd_top
//  gcd_c    in   W       result from gcd_top
// BEHAVIOUR
//  - All outputs are registered. While reset is low, or asynchronously when it
//    falls: state=IDLE, cli_ack=0, cli_c=0, gcd_req=0, gcd_ab=0, rr_ptr=0.
//  - FSM states: IDLE, SEND_A, DROP_A, SEND_B, DROP_B, RESPOND, RELEASE.
//  - IDLE: if cli_req!=0, grant the first set bit searching from rr_ptr upward
//    with wrap. Latch g, A_g and B_g. Drive gcd_ab=A_g, gcd_req=1 -> SEND_A.
//  - SEND_A: hold. When gcd_ack==1: gcd_req=0 -> DROP_A.
//  - DROP_A: when gcd_ack==0: gcd_ab=B_g, gcd_req=1 -> SEND_B.
//  - SEND_B: when gcd_ack==1: cli_c<=gcd_c, gcd_req=0 -> DROP_B.
//  - DROP_B: when gcd_ack==0: cli_ack[g]=1 -> RESPOND.
//  - RESPOND: hold cli_ack[g]=1 and cli_c. When cli_req[g]==0: cli_ack[g]=0,
//    rr_ptr=(g+1) mod NREQ -> RELEASE.
//  - RELEASE: one cycle with all acks low -> IDLE. A client that re-requests
//    back-to-back therefore sees ack low for at least one cycle.
//  - The earliest grant is in the cycle after cli_req is sampled high.
//    Overhead is 4 cycles plus the gcd_top latency.
//  - Operands are latched at grant. Client operand changes after grant are
//    ignored. gcd_ab is stable whenever gcd_req=1.
//  - Only one client is in flight at a time. Requests from other clients wait
//    and are never lost or reordered beyond round-robin order.
//  - Simultaneous requests in IDLE: the lowest index >= rr_ptr wins, with
//    wrap-around.
//  - A client that drops cli_req before being granted is simply not granted.
//    Dropping cli_req after grant and before ack violates the protocol.
//    In that case the sequence completes and the ack pulses for one cycle.
//  - cli_c holds its last result until the next capture.
//  - Reset asserted mid-operation aborts immediately to the reset values.
//    The parent must reset gcd_top in the same cycle.
//  - gcd_ack high in IDLE is ignored. No state ever waits on a client other
//    than g.
// TESTING
//  1 client0 A=12 B=21 alone -> exactly one SEND_A/SEND_B pair on gcd port,
//    gcd_ab=12 then 21; cli_ack[0]=1 with cli_c=3.
//  2 clients 0..3 request together with (29232,488),(49,98),(32768,272),
//    (91,63) -> grants in order 0,1,2,3 with results 8,49,16,7.
//    cli_ack is never more than one bit set.
//  3 after client2 is served, clients 0 and 3 request -> client3 is granted
//    first (rr_ptr=3), then client0.
//  4 client1 changes cli_a from 12 to 99 while in SEND_B -> result still
//    gcd(12,21)=3.
//  5 reset low during SEND_B -> all outputs 0 in the same cycle. After release
//    the pending request is re-served from A and returns the correct result.
//  6 client holds cli_req high after ack -> ack stays high with stable cli_c
//    until req drops. Then ack is low for >=1 cycle before the next grant.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one serial gcd_top between NREQ clients.
// Each client hands over both operands at once; the arbiter feeds A then B to gcd_top over its req/ack handshake and returns the result.
module gcd_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   cli_req,
  input  logic [NREQ*W-1:0] cli_a,
  input  logic [NREQ*W-1:0] cli_b,
  output logic [NREQ-1:0]   cli_ack,
  output logic [W-1:0]      cli_c,
  output logic              gcd_req,
  output logic [W-1:0]      gcd_ab,
  input  logic              gcd_ack,
  input  logic [W-1:0]      gcd_c
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_A, DROP_A, SEND_B, DROP_B, RESPOND, RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [IW-1:0]   g, g_nxt;
  logic [IW-1:0]   pick;
  logic            found;
  logic            load_b;
  logic [W-1:0]    b_lat;
  logic [NREQ-1:0] ack_nxt;
  logic [W-1:0]    c_nxt;
  logic [W-1:0]    ab_nxt;
  logic            req_nxt;
  int              idx;

  // First requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    found = 1'b0;
    pick  = rr_ptr;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cli_req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    rr_nxt    = rr_ptr;
    ack_nxt   = cli_ack;
    c_nxt     = cli_c;
    req_nxt   = gcd_req;
    ab_nxt    = gcd_ab;
    load_b    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          g_nxt     = pick;
          ab_nxt    = cli_a[int'(pick)*W +: W];
          req_nxt   = 1'b1;
          load_b    = 1'b1;
          state_nxt = SEND_A;
        end
      end
      SEND_A: begin
        if (gcd_ack) begin
          req_nxt   = 1'b0;
          state_nxt = DROP_A;
        end
      end
      DROP_A: begin
        if (!gcd_ack) begin
          ab_nxt    = b_lat;
          req_nxt   = 1'b1;
          state_nxt = SEND_B;
        end
      end
      SEND_B: begin
        if (gcd_ack) begin
          c_nxt     = gcd_c;
          req_nxt   = 1'b0;
          state_nxt = DROP_B;
        end
      end
      DROP_B: begin
        if (!gcd_ack) begin
          ack_nxt   = NREQ'(1) << g;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        if (!cli_req[g]) begin
          ack_nxt   = '0;
          rr_nxt    = (g == IW'(NREQ-1)) ? '0 : g + IW'(1);
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      g       <= '0;
      rr_ptr  <= '0;
      cli_ack <= '0;
      cli_c   <= '0;
      gcd_req <= 1'b0;
      gcd_ab  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state   <= state_nxt;
      g       <= g_nxt;
      rr_ptr  <= rr_nxt;
      cli_ack <= ack_nxt;
      cli_c   <= c_nxt;
      gcd_req <= req_nxt;
      gcd_ab  <= ab_nxt;
    end
  end

  // NOTE: the B-operand holding register has no reset; it is always loaded at grant before it is read.
  always_ff @(posedge clk) begin
    if (load_b) b_lat <= cli_b[int'(pick)*W +: W];
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter.
// A behavioural gcd_top responder plus a transaction-level round-robin model, driven by directed and random clients.
module tb_gcd_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   cli_req;
  logic [NREQ*W-1:0] cli_a, cli_b;
  logic [NREQ-1:0]   cli_ack;
  logic [W-1:0]      cli_c;
  logic              gcd_req;
  logic [W-1:0]      gcd_ab;
  logic              gcd_ack = 1'b0;
  logic [W-1:0]      gcd_c   = '0;

  gcd_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
    .cli_ack(cli_ack), .cli_c(cli_c), .gcd_req(gcd_req), .gcd_ab(gcd_ab),
    .gcd_ack(gcd_ack), .gcd_c(gcd_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  bit              busy;
  int              cur, nsend, rr, since_fall, ack_len, n_rise;
  logic [W-1:0]    exp_a, exp_b;
  logic            prev_gcd_req;
  logic [W-1:0]    prev_ab, prev_c;
  logic [NREQ-1:0] prev_ack, req_prev;
  logic [W-1:0]    a_prev [NREQ];
  logic [W-1:0]    b_prev [NREQ];
  int              served_id [$];
  logic [W-1:0]    served_c [$];
  int              served_len [$];
  logic [W-1:0]    ab_log [$];

  // Client behaviour
  bit rand_en;
  int hold_cycles [NREQ];
  int hold_cnt [NREQ];

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural gcd_top: serial A then B over a 4-phase handshake, random latency.
  int           st = 0, dly = 0;
  logic [W-1:0] op_a, op_b;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      st = 0;
      gcd_ack = 1'b0;
    end else begin
      case (st)
        0: if (gcd_req) begin op_a = gcd_ab; dly = $urandom_range(0, 3); st = 1; end
        1: if (dly == 0) begin gcd_ack = 1'b1; st = 2; end else dly--;
        2: if (!gcd_req) begin gcd_ack = 1'b0; gcd_c = W'($urandom); st = 3; end
        3: if (gcd_req) begin op_b = gcd_ab; dly = $urandom_range(0, 3); st = 4; end
        4: if (dly == 0) begin gcd_ack = 1'b1; gcd_c = gcd_f(op_a, op_b); st = 5; end else dly--;
        default: if (!gcd_req) begin gcd_ack = 1'b0; gcd_c = W'($urandom); st = 0; end
      endcase
    end
  end

  // Compare the DUT against the model at one negedge.
  task automatic monitor();
    int              win;
    bit              found;
    logic [NREQ-1:0] onehot_cur;
    if (!reset) begin
      check("reset_outputs", {cli_ack, cli_c, gcd_req, gcd_ab}, 0);
      busy = 0; rr = 0; nsend = 0; since_fall = 100;
      prev_gcd_req = 1'b0;
      prev_ack = '0;
    end else begin
      if (since_fall < 100) since_fall++;
      check("ack_onehot0", $onehot0(cli_ack), 1);
      if (gcd_req && !prev_gcd_req) begin
        n_rise++;
        ab_log.push_back(gcd_ab);
        if (!busy) begin
          found = 0; win = 0;
          for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (rr + k) % NREQ;
            if (!found && req_prev[j]) begin found = 1; win = j; end
          end
          check("grant_has_request", found, 1);
          check("grant_after_release_gap", since_fall >= 2, 1);
          busy = 1; cur = win; nsend = 1;
          exp_a = a_prev[win]; exp_b = b_prev[win];
          check("gcd_ab_a", gcd_ab, exp_a);
        end else begin
          nsend++;
          check("one_pair", nsend, 2);
          check("gcd_ab_b", gcd_ab, exp_b);
        end
      end else if (gcd_req && prev_gcd_req) begin
        check("gcd_ab_stable", gcd_ab, prev_ab);
      end
      if (prev_ack != 0) begin
        check("ack_hold_release", cli_ack, req_prev[cur] ? prev_ack : '0);
        check("cli_c_stable", cli_c, prev_c);
        if (cli_ack == 0) begin
          rr = (cur + 1) % NREQ; busy = 0; nsend = 0; since_fall = 0;
          served_id.push_back(cur); served_c.push_back(prev_c); served_len.push_back(ack_len);
        end else ack_len++;
      end else if (cli_ack != 0) begin
        onehot_cur = '0;
        onehot_cur[cur] = 1'b1;
        check("ack_rise_busy", busy, 1);
        check("ack_target", cli_ack, onehot_cur);
        check("ack_after_pair", nsend, 2);
        check("cli_c_result", cli_c, gcd_f(exp_a, exp_b));
        ack_len = 1;
      end
    end
    prev_gcd_req = gcd_req; prev_ab = gcd_ab; prev_ack = cli_ack; prev_c = cli_c;
    req_prev = cli_req;
    for (int i = 0; i < NREQ; i++) begin
      a_prev[i] = cli_a[i*W +: W];
      b_prev[i] = cli_b[i*W +: W];
    end
  endtask

  task automatic set_client(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    cli_a[i*W +: W] = a;
    cli_b[i*W +: W] = b;
    hold_cycles[i]  = hold;
    hold_cnt[i]     = 0;
    cli_req[i]      = 1'b1;
  endtask

  // Client side: release req after holding ack, optionally issue random traffic.
  task automatic drive();
    int f;
    for (int i = 0; i < NREQ; i++) begin
      if (cli_req[i] && cli_ack[i]) begin
        if (hold_cnt[i] >= hold_cycles[i]) begin
          cli_req[i] = 1'b0;
          hold_cnt[i] = 0;
        end else hold_cnt[i]++;
      end else if (rand_en && !cli_req[i] && !cli_ack[i] && !(busy && cur == i)
                   && $urandom_range(0, 3) == 0) begin
        f = $urandom_range(1, 64);
        set_client(i, W'(f * $urandom_range(0, 1000)), W'(f * $urandom_range(0, 1000)),
                   $urandom_range(0, 2));
      end else if (rand_en && cli_req[i] && !cli_ack[i] && !(busy && cur == i)
                   && $urandom_range(0, 63) == 0) begin
        cli_req[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_served(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (served_id.size() < n && c < budget) begin step(); c++; end
    check(name, served_id.size(), n);
  endtask

  task automatic wait_send_b(input int budget);
    int c;
    c = 0;
    while (!(busy && nsend == 2) && c < budget) begin step(); c++; end
    check("reach_send_b", busy && nsend == 2, 1);
  endtask

  task automatic clear_log();
    served_id.delete(); served_c.delete(); served_len.delete(); ab_log.delete();
  endtask

  initial begin
    int           exp_id [4];
    logic [W-1:0] exp_c [4];
    int           c, rise0;
    bit           drained;
    reset = 1'b0; cli_req = '0; cli_a = '0; cli_b = '0; rand_en = 0;
    busy = 0; cur = 0; nsend = 0; rr = 0; since_fall = 100; ack_len = 0; n_rise = 0;
    prev_gcd_req = 1'b0; prev_ab = '0; prev_c = '0; prev_ack = '0; req_prev = '0;
    for (int i = 0; i < NREQ; i++) begin hold_cycles[i] = 0; hold_cnt[i] = 0; end
    repeat (3) step();
    reset = 1'b1;

    // Four simultaneous requests from rr_ptr=0
    set_client(0, 29232, 488, 0);
    set_client(1, 49, 98, 0);
    set_client(2, 32768, 272, 0);
    set_client(3, 91, 63, 0);
    wait_served(4, 500, "t2_served");
    exp_id = '{0, 1, 2, 3};
    exp_c  = '{8, 49, 16, 7};
    for (int i = 0; i < 4; i++) begin
      check("t2_order", served_id[i], exp_id[i]);
      check("t2_result", served_c[i], exp_c[i]);
    end
    clear_log();

    // Single client 0 request
    rise0 = n_rise;
    set_client(0, 12, 21, 0);
    wait_served(1, 200, "t1_served");
    check("t1_id", served_id[0], 0);
    check("t1_result", served_c[0], 3);
    check("t1_gcd_req_rises", n_rise - rise0, 2);
    check("t1_ab_first", ab_log[0], 12);
    check("t1_ab_second", ab_log[1], 21);
    clear_log();

    // Client 2 alone, then 0 and 3 together: 3 wins from rr_ptr=3
    set_client(2, 100, 40, 0);
    wait_served(1, 200, "t3a_served");
    check("t3a_id", served_id[0], 2);
    repeat (2) step();
    set_client(0, 18, 24, 0);
    set_client(3, 45, 75, 0);
    wait_served(3, 400, "t3_served");
    check("t3_first", served_id[1], 3);
    check("t3_first_c", served_c[1], 15);
    check("t3_second", served_id[2], 0);
    check("t3_second_c", served_c[2], 6);
    clear_log();

    // Operand change after grant is ignored
    set_client(1, 12, 21, 0);
    wait_send_b(200);
    cli_a[1*W +: W] = 99;
    wait_served(1, 200, "t4_served");
    check("t4_id", served_id[0], 1);
    check("t4_result", served_c[0], 3);
    clear_log();

    // Asynchronous reset during SEND_B, then the pending request is re-served
    set_client(0, 100, 75, 0);
    wait_send_b(200);
    #2 reset = 1'b0;
    #1 check("t5_async_reset", {cli_ack, cli_c, gcd_req, gcd_ab}, 0);
    repeat (3) step();
    reset = 1'b1;
    wait_served(1, 200, "t5_served");
    check("t5_id", served_id[0], 0);
    check("t5_result", served_c[0], 25);
    repeat (3) step();
    check("t5_single", served_id.size(), 1);
    clear_log();

    // Held request keeps ack; queued client follows after a gap
    set_client(2, 48, 36, 5);
    set_client(3, 35, 21, 0);
    wait_served(2, 400, "t6_served");
    check("t6_first", served_id[0], 2);
    check("t6_first_c", served_c[0], 12);
    check("t6_ack_len", served_len[0], 6);
    check("t6_second", served_id[1], 3);
    check("t6_second_c", served_c[1], 7);
    clear_log();

    // Random traffic
    rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    c = 0;
    drained = 0;
    while (!drained && c < 1000) begin
      step();
      c++;
      drained = (cli_req == 0) && (cli_ack == 0) && !busy;
    end
    check("rand_drain", drained, 1);
    check("rand_traffic", served_id.size() > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
